// File: rtl/dmem_pkg.sv
// Shared constants and the responder's state encoding for the data-port memory model.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the memory-stage formatter (master) and the responder (slave).
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [31:0]       req_addr;
    logic [STRB_W-1:0] req_strb;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_strb, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_strb, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_bank.sv
// Word array with per-byte-lane write enables and a registered read port.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [STRB_W-1:0] wr_en,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    // Lane-merged write and read-before-write registered read
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (wr_en[i]) begin
                mem_r[wr_addr][BYTE_W*i +: BYTE_W] <= wr_data[BYTE_W*i +: BYTE_W];
            end
        end
        rd_data <= mem_r[rd_addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: accepts one load/store, waits LATENCY cycles, commits to the
// bank and returns the loaded or post-merge word with a range error flag.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);

    state_e            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              wen_r;
    logic [31:0]       addr_r;
    logic [STRB_W-1:0] strb_r;
    logic [DATA_W-1:0] wdata_r;
    logic              req_ready_r;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic [DATA_W-1:0] resp_rdata_r;

    logic              accept_s;
    logic              commit_s;
    logic              in_range_s;
    logic [ADDR_W-1:0] word_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [DATA_W-1:0] merged_s;
    logic [STRB_W-1:0] wr_en_s;

    assign accept_s   = (state_r == ST_IDLE) && bus.req_valid;
    assign commit_s   = (state_r == ST_WAIT) && (cnt_r == CNT_W'(1));
    assign in_range_s = ((addr_r >> (ADDR_W + 2)) == 32'd0);
    assign word_s     = addr_r[ADDR_W+1:2];

    // The bank is read from the incoming address while idle so the old word is
    // already registered by the commit edge, even with a single wait state.
    always_comb begin
        rd_addr_s = word_s;
        merged_s  = rd_data_s;
        wr_en_s   = {STRB_W{1'b0}};
        if (state_r == ST_IDLE) begin
            rd_addr_s = bus.req_addr[ADDR_W+1:2];
        end else begin
            rd_addr_s = word_s;
        end
        for (int i = 0; i < STRB_W; i++) begin
            if (strb_r[i]) begin
                merged_s[BYTE_W*i +: BYTE_W] = wdata_r[BYTE_W*i +: BYTE_W];
            end else begin
                merged_s[BYTE_W*i +: BYTE_W] = rd_data_s[BYTE_W*i +: BYTE_W];
            end
            // Reset on the commit edge must suppress the write.
            wr_en_s[i] = commit_s & wen_r & in_range_s & strb_r[i] & ~rst;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) state_s = ST_WAIT;
                else               state_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (commit_s) state_s = ST_RESP;
                else          state_s = ST_WAIT;
            end
            ST_RESP: begin
                if (bus.resp_ready) state_s = ST_IDLE;
                else                state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, capture, wait counter and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_W'(0);
            wen_r        <= 1'b0;
            addr_r       <= 32'd0;
            strb_r       <= {STRB_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_s;
            req_ready_r  <= (state_s == ST_IDLE);
            resp_valid_r <= (state_s == ST_RESP);
            if (accept_s) begin
                wen_r   <= bus.req_wen;
                addr_r  <= bus.req_addr;
                strb_r  <= bus.req_strb;
                wdata_r <= bus.req_wdata;
                cnt_r   <= CNT_W'(LATENCY);
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (commit_s) begin
                if (!in_range_s) begin
                    resp_err_r   <= 1'b1;
                    resp_rdata_r <= {DATA_W{1'b0}};
                end else if (wen_r) begin
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= merged_s;
                end else begin
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= rd_data_s;
                end
            end
        end
    end

    dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
        .clk     (clk),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s),
        .wr_addr (word_s),
        .wr_en   (wr_en_s),
        .wr_data (wdata_r)
    );

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;

endmodule
